// File: rtl/vrb_ram_slv.sv
// vrb_ram_slv: word-addressed RAM slave with a valid/ready command port and a
// 2-entry in-order response FIFO.  Reads are answered one cycle after
// acceptance; writes honour per-byte lane enables.  The array itself is never
// cleared by reset, so its contents survive a reset pulse.
//
// Build option:
//   VRB_RAM_MISALIGN_ERR_EN - when defined, any access whose byte address is
//   not word aligned is rejected with err=1 and performs no write.  When not
//   defined, the two low address bits are ignored and the access goes to the
//   word that contains the address.

`ifndef AW
`define AW 32
`endif
`ifndef DW
`define DW 32
`endif

module vrb_ram_slv #(
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [`AW-1:0]  BASE_ADDR  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [`AW-1:0]    i_cmd_addr,
    input  logic              i_cmd_read,
    input  logic [`DW-1:0]    i_cmd_wdata,
    input  logic [`DW/8-1:0]  i_cmd_wmask,

    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_err,
    output logic [`DW-1:0]    o_rsp_rdata
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int LANES = `DW / 8;

    // Storage array; deliberately has no reset.
    logic [`DW-1:0]         mem [WORDS];

    // Address decode results for the command currently on the port.
    logic [`AW-1:0]         offset;
    logic [DEPTH_LOG2-1:0]  word_idx;
    logic                   in_range;
    logic                   misaligned;
    logic                   access_err;
    logic                   unused_offset_bits;

    // Handshake qualifiers.
    logic                   accept;
    logic                   pop;
    logic                   do_write;

    // Response value captured into the FIFO on acceptance.
    logic                   rsp_err_next;
    logic [`DW-1:0]         rsp_rdata_next;

    // Response FIFO: two slots, a read pointer, a write pointer and a count.
    logic                   fifo_err  [2];
    logic [`DW-1:0]         fifo_data [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;

    // Translate the byte address into a word index relative to BASE_ADDR;
    // the subtraction wraps, so addresses below the base land far out of range.
    always_comb begin
        offset   = i_cmd_addr - BASE_ADDR;
        word_idx = offset[DEPTH_LOG2+1:2];
        in_range = (offset >> (DEPTH_LOG2 + 2)) == '0;
    end

    // The byte offset within a word never selects data; it only matters for
    // the optional alignment check, which looks at the raw address.
    assign unused_offset_bits = ^offset[1:0];

`ifdef VRB_RAM_MISALIGN_ERR_EN
    assign misaligned = i_cmd_addr[1:0] != 2'b00;
`else
    assign misaligned = 1'b0;
`endif

    assign access_err = !in_range || misaligned;

    // Ready depends only on registered occupancy and reset, never on the
    // response-side handshake, so there is no combinational ready chain.
    assign o_cmd_ready = !rst && (count != 2'd2);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign pop         = o_rsp_valid && i_rsp_ready;
    assign do_write    = accept && !i_cmd_read && !access_err;

    // Build the response for the command being accepted; a write that was
    // issued on the previous edge is already visible in the array here.
    always_comb begin
        rsp_err_next   = access_err;
        rsp_rdata_next = '0;
        if (i_cmd_read && !access_err) begin
            rsp_rdata_next = mem[word_idx];
        end
    end

    // Byte-lane masked array update; only lanes with their enable set change.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_cmd_wmask[k]) begin
                    mem[word_idx][8*k +: 8] <= i_cmd_wdata[8*k +: 8];
                end
            end
        end
    end

    // Response FIFO bookkeeping: push on accept, pop on response handshake,
    // both allowed on the same edge; reset discards anything pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                fifo_err[s]  <= 1'b0;
                fifo_data[s] <= '0;
            end
        end else begin
            if (accept) begin
                fifo_err[wr_ptr]  <= rsp_err_next;
                fifo_data[wr_ptr] <= rsp_rdata_next;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The head slot drives the response port directly from registers, so it
    // stays stable for as long as the consumer stalls.
    assign o_rsp_valid = count != 2'd0;
    assign o_rsp_err   = fifo_err[rd_ptr];
    assign o_rsp_rdata = fifo_data[rd_ptr];

endmodule

// File: tb/tb_vrb_ram_slv.sv
// tb_vrb_ram_slv: self-checking bench for vrb_ram_slv.  A table of commands
// with hand-derived expected responses is streamed back to back; expected
// responses go into a scoreboard queue when a command is accepted and are
// compared when the DUT hands the response over.  Hand-written sequences
// cover response latency, back-pressure and reset in the middle of traffic.
// Expectations for misaligned accesses follow VRB_RAM_MISALIGN_ERR_EN.

`ifndef AW
`define AW 32
`endif
`ifndef DW
`define DW 32
`endif

module tb_vrb_ram_slv;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [`AW-1:0]    i_cmd_addr = '0;
    logic              i_cmd_read = 1'b0;
    logic [`DW-1:0]    i_cmd_wdata = '0;
    logic [`DW/8-1:0]  i_cmd_wmask = '0;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b1;
    logic              o_rsp_err;
    logic [`DW-1:0]    o_rsp_rdata;

`ifdef VRB_RAM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    rsp_t exp_q [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;

    vrb_ram_slv #(
        .DEPTH_LOG2 (10),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_read  (i_cmd_read),
        .i_cmd_wdata (i_cmd_wdata),
        .i_cmd_wmask (i_cmd_wmask),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_err   (o_rsp_err),
        .o_rsp_rdata (o_rsp_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure throughput.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one command and hold it until accepted; the expected response
    // enters the scoreboard on the cycle the handshake will complete.
    task automatic applyStimulus(input logic rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] mask,
                                 input logic exp_err, input logic [31:0] exp_rdata);
        int n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_read  = rd;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        i_cmd_wmask = mask;
        forever begin
            @(negedge clk);
            if (o_cmd_ready) begin
                exp_q.push_back('{err: exp_err, rdata: exp_rdata});
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n >= 50) begin
                checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        i_cmd_valid = 1'b0;
    endtask

    // Wait until every expected response has been delivered.
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_rsp_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_complete", {63'd0, (n < 50)}, 64'd1);
    endtask

    // Response monitor: compare each handed-over response with the scoreboard.
    always @(negedge clk) begin
        if (!rst && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_err_rdata", {o_rsp_err, o_rsp_rdata}, {e.err, e.rdata});
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h1122_3344, 4'h5, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDE22_BE44};
        vecs[5]  = '{1'b0, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'hA5A5_A5A5};
        vecs[7]  = '{1'b1, 32'h0000_1000, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h0,         4'h0, 1'b0, 32'h0102_0304};
        vecs[11] = '{1'b0, 32'h0000_0024, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0024, 32'h0,         4'h0, 1'b0, 32'h1234_5678};
        vecs[14] = '{1'b0, 32'h0000_0024, 32'hAABB_CCDD, 4'hA, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 32'h0000_0024, 32'h0,         4'h0, 1'b0, 32'hAA34_CC78};
        vecs[16] = '{1'b0, 32'h0000_0014, 32'h5566_7788, 4'hF, 1'b0, 32'h0};
        if (MIS) begin
            vecs[17] = '{1'b1, 32'h0000_0012, 32'h0,         4'h0, 1'b1, 32'h0};
            vecs[18] = '{1'b0, 32'h0000_0016, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h0};
            vecs[19] = '{1'b1, 32'h0000_0014, 32'h0,         4'h0, 1'b0, 32'h5566_7788};
        end else begin
            vecs[17] = '{1'b1, 32'h0000_0012, 32'h0,         4'h0, 1'b0, 32'hDE22_BE44};
            vecs[18] = '{1'b0, 32'h0000_0016, 32'hAAAA_AAAA, 4'hF, 1'b0, 32'h0};
            vecs[19] = '{1'b1, 32'h0000_0014, 32'h0,         4'h0, 1'b0, 32'hAAAA_AAAA};
        end

        // Reset state while rst is held.
        @(negedge clk);
        checkOutput("reset_outputs", {o_rsp_valid, o_rsp_err, o_cmd_ready, o_rsp_rdata}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {o_cmd_ready, o_rsp_valid}, 64'b10);
        @(posedge clk);
        #1;

        // Table-driven stream with the consumer always ready: one per cycle.
        $display("[TB] streaming %0d table vectors", NV);
        start_cyc = cyc;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                          vecs[i].exp_err, vecs[i].exp_rdata);
        end
        checkOutput("throughput_cycles", 64'(cyc - start_cyc), 64'(NV));
        drain();

        // One-cycle latency from an empty FIFO.
        checkOutput("idle_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        applyStimulus(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
        checkOutput("latency_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        drain();

        // Back-pressure: two reads fill the FIFO, the third must wait.
        $display("[TB] back-pressure sequence");
        i_rsp_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
        applyStimulus(1'b1, 32'h0000_0024, 32'h0, 4'h0, 1'b0, 32'hAA34_CC78);
        fork
            applyStimulus(1'b1, 32'h0000_0000, 32'h0, 4'h0, 1'b0, 32'hA5A5_A5A5);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("bp_cmd_ready_low", {63'd0, o_cmd_ready}, 64'd0);
                    checkOutput("bp_rsp_hold", {o_rsp_valid, o_rsp_err, o_rsp_rdata},
                                {1'b1, 1'b0, 32'hDE22_BE44});
                end
                @(posedge clk);
                #1;
                i_rsp_ready = 1'b1;
            end
        join
        drain();

        // Reset with two responses pending.
        $display("[TB] reset mid-operation sequence");
        i_rsp_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
        applyStimulus(1'b1, 32'h0000_0024, 32'h0, 4'h0, 1'b0, 32'hAA34_CC78);
        @(negedge clk);
        checkOutput("pre_reset_full", {o_rsp_valid, o_cmd_ready}, 64'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("reset_mid_outputs", {o_rsp_valid, o_rsp_err, o_cmd_ready, o_rsp_rdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_ready", {o_cmd_ready, o_rsp_valid}, 64'b10);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
        applyStimulus(1'b1, 32'h0000_0024, 32'h0, 4'h0, 1'b0, 32'hAA34_CC78);
        applyStimulus(1'b1, 32'h0000_0000, 32'h0, 4'h0, 1'b0, 32'hA5A5_A5A5);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vrb_ram_slv.md
VRB_RAM_SLV -- requirements
Module: vrb_ram_slv

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10: log2 of word count; the array holds 1024 words of `DW bits.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port i_cmd_valid, input, 1: command valid.
REQ-006 SHALL have port o_cmd_ready, output, 1: command ready.
REQ-007 SHALL have port i_cmd_addr, input, `AW: byte address.
REQ-008 SHALL have port i_cmd_read, input, 1: 1 = read, 0 = write.
REQ-009 SHALL have port i_cmd_wdata, input, `DW: write data.
REQ-010 SHALL have port i_cmd_wmask, input, `DW/8: byte-lane write enables; bit k covers wdata[8k+7:8k].
REQ-011 SHALL have port o_rsp_valid, output, 1: response valid.
REQ-012 SHALL have port i_rsp_ready, input, 1: response ready.
REQ-013 SHALL have port o_rsp_err, output, 1: response error.
REQ-014 SHALL have port o_rsp_rdata, output, `DW: read data.

Function
REQ-015 SHALL accept a command on a rising edge where i_cmd_valid & o_cmd_ready; a response SHALL pop on a rising edge where o_rsp_valid & i_rsp_ready.
REQ-016 SHALL hold responses in a 2-entry in-order FIFO; o_cmd_ready = !rst & (count != 2), registered-state only, with no combinational path from i_rsp_ready or i_cmd_valid.
REQ-017 SHALL present the response to a command accepted at edge N as o_rsp_valid=1 in the cycle after edge N (1-cycle latency) when the FIFO was empty.
REQ-018 SHALL allow push and pop on the same edge, leaving count unchanged; with i_rsp_ready held at 1, throughput SHALL be one command per cycle.
REQ-019 SHALL hold o_rsp_valid, o_rsp_err and o_rsp_rdata stable while o_rsp_valid & !i_rsp_ready.
REQ-020 SHALL compute word index = (i_cmd_addr - BASE_ADDR) >> 2, modulo `AW; an index >= 2^DEPTH_LOG2 (including addresses below BASE_ADDR) is out of range.
REQ-021 SHALL, for an in-range read, return the array word at the index, with err=0.
REQ-022 SHALL, for an in-range write, update only the lanes whose wmask bit is 1 at the accepting edge, and return rdata=0, err=0; wmask=0 SHALL return a normal response and write nothing.
REQ-023 SHALL, for an out-of-range access, leave the array unchanged and return err=1, rdata=0.
REQ-024 SHALL return new data for a read accepted at edge N+1 when the same word was written at edge N (read-after-write).
REQ-025 SHALL NOT reset the array contents.

Reset
REQ-026 SHALL, while rst=1, force FIFO count=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0 and o_cmd_ready=0, with no array writes.
REQ-027 SHALL discard pending responses when rst asserts mid-operation, and SHALL assert o_cmd_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, when VRB_RAM_MISALIGN_ERR_EN is defined, treat any access with i_cmd_addr[1:0] != 0 as an error: no write, err=1, rdata=0.
REQ-029 SHALL, when VRB_RAM_MISALIGN_ERR_EN is undefined, ignore i_cmd_addr[1:0]; the access completes on the word containing the address.

Verification
REQ-030 SHALL be tested for write/read: write addr 0x10 data 0xDEADBEEF mask 4'hF, then read 0x10 -> rsp rdata 0xDEADBEEF, err 0, one cycle after acceptance.
REQ-031 SHALL be tested for byte mask: write 0x10 data 0x11223344 mask 4'b0101 over 0xDEADBEEF -> read 0x10 returns 0xDE22BE44.
REQ-032 SHALL be tested for back-pressure: i_rsp_ready=0, issue 3 reads -> 2 accepted, o_cmd_ready=0 and rsp held stable; i_rsp_ready=1 -> responses return in order and the third read is accepted.
REQ-033 SHALL be tested for out-of-range, with DEPTH_LOG2=10 and BASE_ADDR=0: write 0x1000 -> err=1; array word 0 unchanged.
REQ-034 SHALL be tested for misalignment: read 0x12 -> err=1, rdata=0 with VRB_RAM_MISALIGN_ERR_EN; err=0 with word 0x10 data without it.
REQ-035 SHALL be tested for reset mid-operation: assert rst with 2 responses pending -> o_rsp_valid=0 immediately; after release o_cmd_ready=1 and array data is retained.
